// File: rtl/ff_pipe_vr.sv
// Elastic register pipeline: DEPTH stages with per-stage valid bits, valid/ready
// handshake on both ends, bubble collapsing, global stall (en), flush and occupancy count.
module ff_pipe_vr #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 2,
  parameter bit CLR_DATA = 1'b1,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] move, load;
  logic [CW-1:0]    count_q, count_d;
  logic             go;
  logic             in_take, out_take;

  // Flush and reset block every handshake and every stage transfer in their cycle.
  assign go = en & ~flush & ~rst;

  // Walk from the output side back to the input: a stage may advance when the
  // stage after it is empty or is itself advancing this cycle.
  always_comb begin : advance
    logic ds_free;
    ds_free = out_ready;
    move    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      move[k] = go & valid_q[k] & ds_free;
      ds_free = ~valid_q[k] | move[k];
    end
    in_ready = go & ds_free;
  end

  assign out_valid = valid_q[DEPTH-1] & go;
  assign in_take   = in_valid & in_ready;
  assign out_take  = out_valid & out_ready;

  // NOTE: every output of this block gets a default first, so no path leaves it
  // unassigned and no latch can be inferred.
  always_comb begin
    data_d  = data_q;
    load    = '0;
    load[0] = in_take;
    if (in_take) data_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = move[k-1];
      if (move[k-1]) data_d[k] = data_q[k-1];
    end
    valid_d = load | (valid_q & ~move);
    count_d = count_q + CW'(in_take) - CW'(out_take);
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which the stage-to-stage shift relies on.
  always_ff @(posedge CLK) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // NOTE: the data registers are cleared only when CLR_DATA is set; otherwise
  // they are plain enabled registers and the valid bits alone define occupancy.
  always_ff @(posedge CLK) begin
    if (rst && CLR_DATA) data_q <= '{default: '0};
    else                 data_q <= data_d;
  end

  assign out_data = data_q[DEPTH-1];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_ff_pipe_vr.sv
// Directed bench for ff_pipe_vr (DEPTH=3): a scoreboard queue tracks accepted
// words and is compared whenever the pipeline hands a word out.
module tb_ff_pipe_vr;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, en, flush, in_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_ready, out_valid, empty, full;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             k_in_ready, k_out_valid, k_empty, k_full;
  logic [WIDTH-1:0] k_out_data;
  logic [CW-1:0]    k_count;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] nxt;

  always #5 clk = ~clk;

  ff_pipe_vr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLR_DATA(1'b1)) dut (
    .CLK(clk), .rst(rst), .en(en), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .empty(empty), .full(full)
  );

  ff_pipe_vr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLR_DATA(1'b0)) dut_keep (
    .CLK(clk), .rst(rst), .en(en), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(k_in_ready),
    .out_data(k_out_data), .out_valid(k_out_valid), .out_ready(out_ready),
    .count(k_count), .empty(k_empty), .full(k_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs change just after posedge, so negedge sees the values
  // that the next posedge will act on.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else                chk("sb_data", out_data, sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick;
    tick;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;

    // Continuous stream, latency DEPTH, full throughput.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'(i + 1);
      #1;
      chk("t1_in_ready", in_ready, 1);
      chk("t1_out_valid", out_valid, 32'(i >= 3));
      chk("t1_count", count, (i < 3) ? 32'(i) : 32'd3);
      if (i == 3) chk("t1_first_word", out_data, 1);
      tick;
    end
    in_valid = 1'b0;
    tick; tick; tick;
    chk("t1_empty", empty, 1);
    chk("t1_sb_drained", sb.size(), 0);

    // Backpressure: three accepted, fourth refused until out_ready rises.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA + 32'(i);
      #1;
      chk("t2_in_ready", in_ready, 32'(i < 3));
      if (i == 3) begin
        chk("t2_count", count, 3);
        chk("t2_full", full, 1);
        chk("t2_out_valid_held", out_valid, 1);
      end
      tick;
    end
    out_ready = 1'b1;
    #1;
    chk("t2_in_ready_full_and_ready", in_ready, 1);
    chk("t2_out_a", out_data, 32'hA);
    tick;
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t2_out_valid", out_valid, 1);
      chk("t2_out_seq", out_data, 32'hB + 32'(j));
      tick;
    end
    chk("t2_empty", empty, 1);

    // Bubble collapse: 0x22 must sit directly behind 0x11.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'h11; tick;
    in_valid  = 1'b0; tick; tick;
    in_valid  = 1'b1; in_data = 32'h22; tick;
    in_valid  = 1'b0; tick;
    chk("t3_count", count, 2);
    chk("t3_out_data", out_data, 32'h11);
    out_ready = 1'b1;
    #1;
    chk("t3_out_valid", out_valid, 1);
    tick;
    chk("t3_back_to_back_valid", out_valid, 1);
    chk("t3_back_to_back_data", out_data, 32'h22);
    tick;
    chk("t3_empty", empty, 1);

    // Global stall mid-stream.
    nxt = 32'h100;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = nxt;
      #1;
      chk("t4_in_ready", in_ready, 1);
      nxt++;
      tick;
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = nxt;
      #1;
      chk("t4_stall_in_ready", in_ready, 0);
      chk("t4_stall_out_valid", out_valid, 0);
      chk("t4_stall_count", count, 3);
      chk("t4_stall_out_data", out_data, 32'h102);
      tick;
    end
    en = 1'b1;
    #1;
    chk("t4_resume_out_valid", out_valid, 1);
    chk("t4_resume_out_data", out_data, 32'h102);
    for (int i = 0; i < 4; i++) begin
      in_data = nxt;
      #1;
      chk("t4_resume_in_ready", in_ready, 1);
      nxt++;
      tick;
    end
    in_valid = 1'b0;
    tick; tick; tick;
    chk("t4_empty", empty, 1);
    chk("t4_sb_drained", sb.size(), 0);

    // Flush with two words inside and a word on offer.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'h31; tick;
    in_data   = 32'h32; tick;
    in_valid  = 1'b0; tick;
    chk("t5_count", count, 2);
    chk("t5_out_data", out_data, 32'h31);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h33; out_ready = 1'b1;
    #1;
    chk("t5_flush_in_ready", in_ready, 0);
    chk("t5_flush_out_valid", out_valid, 0);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("t5_count_after", count, 0);
    chk("t5_empty_after", empty, 1);
    chk("t5_out_data_kept", out_data, 32'h31);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_ghost_word", out_valid, 0);
      tick;
    end

    // Reset while full and stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'h41; tick;
    in_data   = 32'h42; tick;
    in_data   = 32'h43; tick;
    in_valid  = 1'b0;
    #1;
    chk("t6_full", full, 1);
    chk("t6_out_data", out_data, 32'h41);
    chk("t6_keep_out_data", k_out_data, 32'h41);
    rst = 1'b1;
    #1;
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("t6_clr_out_data", out_data, 0);
    chk("t6_clr_count", count, 0);
    chk("t6_clr_out_valid", out_valid, 0);
    chk("t6_clr_empty", empty, 1);
    chk("t6_keep_out_data_after", k_out_data, 32'h41);
    chk("t6_keep_count", k_count, 0);
    chk("t6_keep_out_valid", k_out_valid, 0);
    chk("t6_keep_full", k_full, 0);
    tick;
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ff_pipe_vr.md
Name: ff_pipe_vr

Overview:
- Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit registers with per-stage valid bits and valid/ready handshake on both sides.
- Generalises the plain enable/reset register used in the bcrypt datapath. Adds bubble collapsing, backpressure, a global stall (en), flush, and an occupancy count.
- Used between bcrypt cores and arbiter/output logic wherever timing slack needs register stages that must not drop or duplicate words.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 2, number of register stages (>=1).
- CLR_DATA, 1, 1 = data registers zeroed by rst; 0 = data registers keep their value on rst (valid bits always clear).
- CW, $clog2(DEPTH+1), width of count (derived; not to be overridden).

Ports:
- CLK  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock CLK
- en  in  1  global advance enable; 0 freezes the whole pipeline
- flush  in  1  synchronous clear of all valid bits
- in_data  in  WIDTH  input word
- in_valid  in  1  input word present
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  WIDTH  word in last stage (registered)
- out_valid  out  1  out_data valid; gated by en
- out_ready  in  1  consumer takes the word
- count  out  CW  number of valid stages
- empty  out  1  count==0
- full  out  1  count==DEPTH

Behaviour:
- Stage k holds d[k] and v[k]; stage 0 is the input side, stage DEPTH-1 feeds out_data/out_valid.
- move[DEPTH-1] = en & v[DEPTH-1] & out_ready.
- move[k] for k<DEPTH-1 = en & v[k] & (~v[k+1] | move[k+1]). Bubbles collapse: a word advances whenever the next stage is free or freeing.
- in_ready = en & (~v[0] | move[0]). Equivalent to en & (count<DEPTH | out_ready).
- in_take = in_valid & in_ready. out_take = out_valid & out_ready.
- out_valid = v[DEPTH-1] & en. No handshake completes while en=0.
- load[0] = in_take; load[k] = move[k-1]. On load[k], d[k] <= d[k-1] (stage 0 loads in_data).
- v[k] next = load[k] | (v[k] & ~move[k]).
- count next = count + in_take - out_take. Never exceeds DEPTH and never underflows.
- in_ready depends combinationally on out_ready through DEPTH stages. This path is accepted; DEPTH is kept small (<=4) where timing matters.
- Latency: a word taken in cycle t shows out_valid in cycle t+DEPTH when unstalled. Throughput is 1 word/cycle.
- Ordering: FIFO order is always preserved; no loss or duplication under any en/out_ready pattern.
- en=0: all v/d/count hold; in_ready=0, out_valid=0; out_data still shows d[DEPTH-1].
- Priority: rst > flush > normal operation.
- rst: all v=0, count=0. If CLR_DATA=1, all d=0 (out_data=0); if CLR_DATA=0, d unchanged.
- flush (effective regardless of en): all v=0 and count=0 next cycle; d unchanged. in_ready and out_valid are forced 0 in the flush cycle, so no handshake completes.
- Simultaneous in_take and out_take when full: legal; count stays DEPTH.
- DEPTH=1: single skid-less register; in_ready = en & (~v[0] | out_ready).
- Reset values: in_ready=0 during rst, then en-dependent; out_valid=0; count=0; empty=1; full=0; out_data=0 if CLR_DATA=1.

Test Plan:
- WIDTH=32, DEPTH=3, en=1, out_ready=1, stream 1,2,3,... from cycle 0 -> out_valid first in cycle 3 with out_data=1. Then one word per cycle in order; count=3 steady; in_ready never drops.
- out_ready=0, offer 0xA,0xB,0xC,0xD -> three accepted; in_ready=0 on 0xD; count=3, full=1. Raise out_ready -> 0xA,0xB,0xC,0xD emerge on consecutive cycles; then empty=1.
- out_ready=0, push 0x11, idle 2 cycles, push 0x22 -> count=2 with 0x11 in stage 2 and 0x22 collapsed into stage 1. Release -> 0x11, 0x22 on back-to-back cycles.
- Mid-stream en=0 for 4 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, count and contents frozen. Resume -> sequence continues with no gap word lost or duplicated.
- count=2, assert flush with in_valid=1 -> in_ready=0 that cycle; next cycle count=0, empty=1; flushed and offered words never appear; out_data unchanged.
- rst during a full stall: CLR_DATA=1 -> out_data=0, count=0, out_valid=0. CLR_DATA=0 -> out_data retains last value, count=0, out_valid=0.
